// File: rtl/ext_bus_arbiter_pkg.sv
// Shared types for the external bus arbiter: FSM state encoding and wait counter width.
package pa_cpu;
    typedef enum logic [1:0] {IDLE, ACCESS, DMA_GRANT, DMA_RELEASE} e_bus_state;
    localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/ext_bus_arbiter.sv
// External bus owner: sequences CPU accesses (fixed waits, then pin_wait stretch) and grants DMA at access boundaries.
// Optional BUS_TIMEOUT_EN macro adds a pin_wait timeout that forces completion and sets sticky bus_err.
module ext_bus_arbiter
    import pa_cpu::*;
#(
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cpu_rd_req,
    input  logic        cpu_wr_req,
    input  logic        cpu_mem_io,
    input  logic [21:0] cpu_addr,
    input  logic        cpu_halt,
    output logic        cpu_done,
    input  logic        dma_req,
    output logic        dma_ack,
    input  logic        pin_wait,
    output logic [21:0] bus_addr,
    output logic        bus_mem_io,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        bus_oe,
    output logic        bus_err,
    input  logic        bus_err_clr
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    e_bus_state              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q;
    logic [21:0]             addr_q;
    logic                    mem_io_q, rd_q, wr_q, dma_owed_q;
    logic                    valid_req, wait_zero, timeout_hit;
    logic                    start, done, strobe_en, oe_c, ack_c;

    // Simultaneous read and write is treated as no request at all.
    assign valid_req = cpu_rd_req ^ cpu_wr_req;
    assign wait_zero = (wait_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        done      = 1'b0;
        strobe_en = 1'b0;
        oe_c      = 1'b0;
        ack_c     = 1'b0;
        case (state_q)
            IDLE: begin
                oe_c = ~cpu_halt;
                if (dma_req & (dma_owed_q | ~valid_req)) begin
                    state_d = DMA_GRANT;
                end else if (valid_req) begin
                    state_d = ACCESS;
                    start   = 1'b1;
                end
            end
            ACCESS: begin
                oe_c      = 1'b1;
                strobe_en = 1'b1;
                if (wait_zero & (~pin_wait | timeout_hit)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            DMA_GRANT: begin
                ack_c = 1'b1;
                if (~dma_req) state_d = DMA_RELEASE;
            end
            DMA_RELEASE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // The IDLE drive enable is combinational, so mask it while reset is held.
    assign bus_oe     = oe_c & ~arst;
    assign cpu_done   = done;
    assign dma_ack    = ack_c;
    assign bus_rd     = strobe_en & rd_q;
    assign bus_wr     = strobe_en & wr_q;
    assign bus_addr   = addr_q;
    assign bus_mem_io = mem_io_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            mem_io_q   <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dma_owed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q     <= cpu_addr;
                mem_io_q   <= cpu_mem_io;
                rd_q       <= cpu_rd_req;
                wr_q       <= cpu_wr_req;
                wait_cnt_q <= WAIT_INIT;
            end else if ((state_q == ACCESS) && !wait_zero) begin
                wait_cnt_q <= wait_cnt_q - 1'b1;
            end
            // A DMA request seen at completion wins the following IDLE cycle.
            if (done)
                dma_owed_q <= dma_req;
            else if (state_q == DMA_GRANT)
                dma_owed_q <= 1'b0;
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       bus_err_q;
    logic       stalled;

    assign stalled     = (state_q == ACCESS) & wait_zero & pin_wait;
    assign timeout_hit = (to_cnt_q == 8'(TIMEOUT_CYCLES));
    assign bus_err     = bus_err_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q != ACCESS)
                to_cnt_q <= '0;
            else if (stalled & ~timeout_hit)
                to_cnt_q <= to_cnt_q + 1'b1;
            if (stalled & timeout_hit)
                bus_err_q <= 1'b1;
            else if (bus_err_clr)
                bus_err_q <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = bus_err_clr;
    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Randomized transaction-level bench for ext_bus_arbiter; expected timing derived from the access/grant rules.
module tb_ext_bus_arbiter;
    localparam int W = 1;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cpu_rd_req = 1'b0, cpu_wr_req = 1'b0, cpu_mem_io = 1'b0, cpu_halt = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic        dma_req = 1'b0, pin_wait = 1'b0, bus_err_clr = 1'b0;
    logic        cpu_done, dma_ack, bus_mem_io, bus_rd, bus_wr, bus_oe, bus_err;
    logic [21:0] bus_addr;

    int n_chk = 0;
    int n_fail = 0;

    ext_bus_arbiter #(.WAIT_STATES(W), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .arst(arst),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_mem_io(cpu_mem_io),
        .cpu_addr(cpu_addr), .cpu_halt(cpu_halt), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_ack(dma_ack), .pin_wait(pin_wait),
        .bus_addr(bus_addr), .bus_mem_io(bus_mem_io), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_oe(bus_oe), .bus_err(bus_err), .bus_err_clr(bus_err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag, input logic exp_oe, input logic exp_ack);
        check({tag, "_done"}, cpu_done, 0);
        check({tag, "_rd"}, bus_rd, 0);
        check({tag, "_wr"}, bus_wr, 0);
        check({tag, "_oe"}, bus_oe, exp_oe);
        check({tag, "_ack"}, dma_ack, exp_ack);
    endtask

    // Access occupies W+1+stall cycles; pin_wait only matters once the fixed waits are spent.
    task automatic access_phase(input logic [21:0] addr, input logic wr, input logic mio,
                                input int stall, input logic dma_mid);
        int last;
        last = W + 1 + stall;
        for (int i = 1; i <= last; i++) begin
            tick();
            pin_wait = (i > W) && (i <= W + stall);
            if (dma_mid && i == 1) dma_req = 1'b1;
            smp();
            check("acc_oe", bus_oe, 1);
            check("acc_rd", bus_rd, !wr);
            check("acc_wr", bus_wr, wr);
            check("acc_addr", bus_addr, addr);
            check("acc_mio", bus_mem_io, mio);
            check("acc_done", cpu_done, (i == last));
            check("acc_ack", dma_ack, 0);
        end
    endtask

    // dma_mode: 0 none, 1 raised with the request in IDLE, 2 raised mid-access.
    task automatic do_access(input logic [21:0] addr, input logic wr, input logic mio, input int stall,
                             input int dma_mode, input int hold, input logic rereq);
        tick();
        cpu_addr = addr; cpu_mem_io = mio; cpu_rd_req = !wr; cpu_wr_req = wr;
        if (dma_mode == 1) dma_req = 1'b1;
        smp();
        check_quiet("idle", 1'b1, 1'b0);
        access_phase(addr, wr, mio, stall, dma_mode == 2);
        tick();
        pin_wait = 1'b0;
        if (!(rereq && dma_mode != 0)) begin
            cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
        end
        smp();
        check_quiet("post", 1'b1, 1'b0);
        if (dma_mode != 0) begin
            for (int k = 0; k < hold; k++) begin
                tick(); smp();
                check_quiet("grant", 1'b0, 1'b1);
            end
            tick(); dma_req = 1'b0; smp();
            check_quiet("grant_drop", 1'b0, 1'b1);
            tick(); smp();
            check_quiet("release", 1'b0, 1'b0);
            if (rereq) begin
                tick(); smp();
                check_quiet("reidle", 1'b1, 1'b0);
                access_phase(addr, wr, mio, 0, 1'b0);
                tick(); cpu_rd_req = 1'b0; cpu_wr_req = 1'b0; smp();
                check_quiet("repost", 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_oe", bus_oe, 0);
        check("rst_ack", dma_ack, 0);
        check("rst_rdwr", {bus_rd, bus_wr, cpu_done}, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_err", bus_err, 0);
        tick(); arst = 1'b0; smp();
        check_quiet("rst_idle", 1'b1, 1'b0);

        do_access(22'h012345, 1'b0, 1'b1, 0, 0, 1, 1'b0);
        do_access(22'h2a5a5a, 1'b1, 1'b0, 3, 0, 1, 1'b0);
        do_access(22'h155555, 1'b0, 1'b1, 0, 2, 2, 1'b1);
        do_access(22'h3c0ffe, 1'b0, 1'b0, 1, 1, 1, 1'b0);

        // Illegal simultaneous read/write is ignored.
        tick(); cpu_rd_req = 1'b1; cpu_wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp(); check_quiet("illegal", 1'b1, 1'b0); tick();
        end
        cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;

        // Halted CPU releases the bus yet still allows DMA.
        cpu_halt = 1'b1; smp();
        check_quiet("halt", 1'b0, 1'b0);
        tick(); dma_req = 1'b1; smp(); check_quiet("halt_req", 1'b0, 1'b0);
        tick(); smp(); check_quiet("halt_grant", 1'b0, 1'b1);
        tick(); dma_req = 1'b0; smp(); check_quiet("halt_drop", 1'b0, 1'b1);
        tick(); smp(); check_quiet("halt_rel", 1'b0, 1'b0);
        tick(); cpu_halt = 1'b0; smp(); check_quiet("unhalt", 1'b1, 1'b0);

        // Reset mid-access, request held through it.
        tick(); cpu_addr = 22'h0abcde; cpu_mem_io = 1'b1; cpu_rd_req = 1'b1; smp();
        tick(); smp(); check("pre_rst_rd", bus_rd, 1);
        #1 arst = 1'b1; #1;
        check("mid_rst_outs", {cpu_done, bus_rd, bus_wr, bus_oe, dma_ack}, 0);
        check("mid_rst_addr", bus_addr, 0);
        tick(); arst = 1'b0; smp();
        check_quiet("rst_rel", 1'b1, 1'b0);
        access_phase(22'h0abcde, 1'b0, 1'b1, 0, 1'b0);
        tick(); cpu_rd_req = 1'b0; smp(); check_quiet("rst_post", 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [21:0] a;
            int dm;
            a  = 22'($urandom);
            dm = $urandom_range(0, 2);
            do_access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      dm, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

`ifdef BUS_TIMEOUT_EN
        tick(); cpu_addr = 22'h300001; cpu_wr_req = 1'b1; smp();
        for (int i = 1; i <= W + 5; i++) begin
            tick(); pin_wait = (i > W); smp();
            check("to_done", cpu_done, (i == W + 5));
            check("to_wr", bus_wr, 1);
        end
        tick(); pin_wait = 1'b0; cpu_wr_req = 1'b0; smp();
        check("to_err_set", bus_err, 1);
        tick(); bus_err_clr = 1'b1; smp(); check("to_err_hold", bus_err, 1);
        tick(); bus_err_clr = 1'b0; smp(); check("to_err_clr", bus_err, 0);
`else
        tick(); bus_err_clr = 1'b1; smp(); check("err_tied", bus_err, 0);
        tick(); bus_err_clr = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
